adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one adder (2..8).
REQ-002 SHALL have parameter SIZE, default 4, meaning operand width in bits.
REQ-003 SHALL have parameter ADD_LAT, default 1, meaning adder cycles from add_valid to add_c valid (1..7).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  meaning per-requester operation request.
REQ-007 SHALL have port req_ready  output  NUM_REQ  meaning per-requester accept; at most one bit high.
REQ-008 SHALL have port req_a  input  NUM_REQ x SIZE  meaning operand A per requester.
REQ-009 SHALL have port req_b  input  NUM_REQ x SIZE  meaning operand B per requester.
REQ-010 SHALL have port add_a  output  SIZE  meaning operand A driven to the shared adder.
REQ-011 SHALL have port add_b  output  SIZE  meaning operand B driven to the shared adder.
REQ-012 SHALL have port add_valid  output  1  meaning one-cycle issue strobe to the adder.
REQ-013 SHALL have port add_c  input  SIZE+3  meaning adder result, valid ADD_LAT cycles after add_valid.
REQ-014 SHALL have port rsp_valid  output  NUM_REQ  meaning one-cycle result strobe to the owning requester.
REQ-015 SHALL have port rsp_c  output  SIZE+3  meaning registered result, valid while any rsp_valid bit is high.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP; only one operation is in flight at a time.
REQ-017 SHALL, in IDLE with any req_valid high, assert req_ready combinationally for the round-robin winner g, capture req_a[g]/req_b[g], and move to ISSUE.
REQ-018 SHALL choose winner g as the first requester with req_valid high, searching upward from the priority pointer with wrap from NUM_REQ-1 to 0.
REQ-019 SHALL set the priority pointer to (g+1) mod NUM_REQ on each grant.
REQ-020 SHALL, in ISSUE, drive add_valid=1 for exactly one cycle with the captured operands, then move to WAIT.
REQ-021 SHALL, in WAIT, count ADD_LAT cycles after the add_valid cycle, capture add_c on the final count, then move to RESP.
REQ-022 SHALL, in RESP, drive rsp_valid[g]=1 and rsp_c for exactly one cycle, then return to IDLE.
REQ-023 SHALL hold add_a/add_b stable from ISSUE through WAIT.
REQ-024 SHALL produce a latency of ADD_LAT+2 cycles from the req handshake cycle to the rsp_valid cycle, giving one operation per ADD_LAT+3 cycles.
REQ-025 SHALL keep req_ready at 0 outside IDLE.
REQ-026 SHALL NOT grant a requester whose req_valid drops before a grant.
REQ-027 SHALL keep rsp_valid free of backpressure; requesters sample it in the RESP cycle.

Reset
REQ-028 SHALL, when reset is low at a clock edge, enter IDLE, set the pointer to 0, and drive req_ready, add_valid and rsp_valid to 0 and add_a, add_b and rsp_c to 0.
REQ-029 SHALL, on reset mid-operation, abandon the in-flight operation with no rsp_valid, and ignore any later add_c.

Configuration
REQ-030 SHALL, with ADDER_ARB_STATS_EN defined, add output stat_ops (16 bits), counting completed RESP cycles, saturating at 16'hFFFF and reset to 0.
REQ-031 SHALL, without ADDER_ARB_STATS_EN, omit the stat_ops port and its logic entirely.

Structure
REQ-032 SHALL place the FSM state enum and the result-width constant (SIZE+3) in shared package adder_arb_pkg.
REQ-033 SHALL implement the round-robin winner selection as sub-module rr_arbiter, with inputs req and ptr and outputs grant (one-hot) and any.

Verification
REQ-034 SHALL cover a single request: req 0, a=3, b=4, ADD_LAT=1, adder model returns 7 -> add_valid at T+1, rsp_valid[0] at T+3 with rsp_c=7.
REQ-035 SHALL cover simultaneous requests: all 4 req_valid held high from reset -> grants in order 0,1,2,3,0, with one grant every 4 cycles.
REQ-036 SHALL cover pointer wrap: pointer=3, req_valid=4'b1001 -> grant 3, then grant 0.
REQ-037 SHALL cover reset mid-operation: reset low during WAIT -> no rsp_valid, IDLE next cycle, next grant to requester 0.
REQ-038 SHALL cover maximum operands: a=b=15 -> rsp_c=30 with no truncation.
REQ-039 SHALL cover stats saturation: with ADDER_ARB_STATS_EN, stat_ops forced near 16'hFFFF plus 2 operations -> holds at 16'hFFFF.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared FSM state type and result-width constant for adder_arbiter
package adder_arb_pkg;

    // Sequencer states; one operation in flight at a time
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Result width is SIZE + RES_EXTRA bits, leaving headroom above the operand width
    localparam int RES_EXTRA = 3;

    // Width of the adder-latency counter; covers ADD_LAT up to 7
    localparam int CNT_W = 3;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - round-robin winner search starting at a priority pointer
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [PW:0] idx;
    logic        found;

    // Walk upward from ptr with wrap and grant the first active requester
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one adder among NUM_REQ requesters; ADDER_ARB_STATS_EN adds stat_ops
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][SIZE-1:0]      req_a,
    input  logic [NUM_REQ-1:0][SIZE-1:0]      req_b,
    output logic [SIZE-1:0]                   add_a,
    output logic [SIZE-1:0]                   add_b,
    output logic                              add_valid,
    input  logic [SIZE+RES_EXTRA-1:0]         add_c,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [SIZE+RES_EXTRA-1:0]         rsp_c
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]                       stat_ops
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       gidx;
    logic [PW-1:0]       next_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  owner;
    logic                any;
    logic [CNT_W-1:0]    cnt;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .any   (any)
    );

    // One-hot grant to index, and the pointer value that follows this winner
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
            end
        end
        next_ptr = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
    end

    // Accept is only offered while idle and out of reset
    assign req_ready = (state == IDLE && reset) ? grant : '0;

    // Sequencer: grant, issue one strobe, wait out the adder latency, return the result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= '0;
            rsp_c     <= '0;
        end else begin
            add_valid <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        add_a     <= req_a[gidx];
                        add_b     <= req_b[gidx];
                        owner     <= grant;
                        ptr       <= next_ptr;
                        add_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_W'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CNT_W'(ADD_LAT)) begin
                        rsp_c     <= add_c;
                        rsp_valid <= owner;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    // Count completed responses, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_ops <= '0;
        end else if (state == RESP && stat_ops != 16'hFFFF) begin
            stat_ops <= stat_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter; ADDER_ARB_STATS_EN enables stat_ops checks
module tb_adder_arbiter;

    logic              clk;
    logic              reset;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][3:0]   req_a;
    logic [3:0][3:0]   req_b;
    logic [3:0]        add_a;
    logic [3:0]        add_b;
    logic              add_valid;
    logic [6:0]        add_c;
    logic [3:0]        rsp_valid;
    logic [6:0]        rsp_c;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]       stat_ops;
`endif

    int total = 0;
    int bad   = 0;

    adder_arbiter #(
        .NUM_REQ (4),
        .SIZE    (4),
        .ADD_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_valid (add_valid),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_c     (rsp_c)
`ifdef ADDER_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle adder; drives a junk value outside the valid result cycle
    always @(posedge clk) begin
        add_c <= add_valid ? ({3'b000, add_a} + {3'b000, add_b}) : 7'h55;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation: handshake, issue, wait, response
    task automatic do_op(input string tag, input logic [3:0] rv, input logic [3:0] eg, input logic [6:0] es);
        req_valid = rv;
        #1;
        check({tag, "_ready"}, {28'd0, req_ready}, {28'd0, eg});
        step();
        req_valid = 4'b0000;
        check({tag, "_issue"}, {31'd0, add_valid}, 32'd1);
        step();
        step();
        check({tag, "_rsp"}, {28'd0, rsp_valid}, {28'd0, eg});
        check({tag, "_c"}, {25'd0, rsp_c}, {25'd0, es});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        step();
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_addv",  {31'd0, add_valid}, 32'd0);
        check("rst_rspv",  {28'd0, rsp_valid}, 32'd0);
        check("rst_adda",  {28'd0, add_a}, 32'd0);
        check("rst_addb",  {28'd0, add_b}, 32'd0);
        check("rst_rspc",  {25'd0, rsp_c}, 32'd0);
`ifdef ADDER_ARB_STATS_EN
        check("rst_stat",  {16'd0, stat_ops}, 32'd0);
`endif
        reset = 1'b1;

        // Single request: 3 + 4 from requester 0
        req_a[0]  = 4'd3;
        req_b[0]  = 4'd4;
        req_valid = 4'b0001;
        #1;
        check("single_ready", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        check("single_addv1", {31'd0, add_valid}, 32'd1);
        check("single_adda",  {28'd0, add_a}, 32'd3);
        check("single_addb",  {28'd0, add_b}, 32'd4);
        check("single_busy",  {28'd0, req_ready}, 32'd0);
        step();
        check("single_addv2", {31'd0, add_valid}, 32'd0);
        check("single_hold",  {28'd0, add_a}, 32'd3);
        check("single_norsp", {28'd0, rsp_valid}, 32'd0);
        step();
        check("single_rspv",  {28'd0, rsp_valid}, 32'h1);
        check("single_rspc",  {25'd0, rsp_c}, 32'd7);
        step();
        check("single_rspoff", {28'd0, rsp_valid}, 32'd0);

        // Maximum operands on requester 1 (pointer now 1)
        req_a[1] = 4'd15;
        req_b[1] = 4'd15;
        do_op("max", 4'b0010, 4'b0010, 7'd30);

        // Simultaneous requests from reset: grants 0,1,2,3,0 every 4 cycles
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 4'(i + 1);
            req_b[i] = 4'(i + 5);
        end
        reset     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("rst_gate_ready", {28'd0, req_ready}, 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] eg;
            logic [3:0] er;
            logic [6:0] ec;
            eg = (k % 4 == 0) ? 4'(1 << ((k / 4) % 4)) : 4'b0000;
            er = (k % 4 == 3) ? 4'(1 << ((k / 4) % 4)) : 4'b0000;
            ec = 7'(2 * ((k / 4) % 4) + 6);
            #1;
            check($sformatf("sim_ready_%0d", k), {28'd0, req_ready}, {28'd0, eg});
            check($sformatf("sim_rsp_%0d", k), {28'd0, rsp_valid}, {28'd0, er});
            if (k % 4 == 3) begin
                check($sformatf("sim_c_%0d", k), {25'd0, rsp_c}, {25'd0, ec});
            end
            if (k == 19) begin
                req_valid = 4'b0000;
            end
            @(posedge clk);
        end
        #1;

        // No request pending: nothing granted, nothing issued
        check("idle_ready", {28'd0, req_ready}, 32'd0);
        step();
        check("idle_addv", {31'd0, add_valid}, 32'd0);

        // Pointer wrap: bring pointer to 3, then 4'b1001 grants 3 then 0
        do_op("to_ptr3", 4'b0100, 4'b0100, 7'd10);
        do_op("wrap3",   4'b1001, 4'b1000, 7'd12);
        do_op("wrap0",   4'b1001, 4'b0001, 7'd6);

        // Reset during WAIT: abandoned, pointer back to 0
        req_valid = 4'b0100;
        #1;
        check("mid_ready", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        step();
        reset = 1'b0;
        step();
        check("mid_norsp", {28'd0, rsp_valid}, 32'd0);
        check("mid_adda",  {28'd0, add_a}, 32'd0);
        reset = 1'b1;
        step();
        check("mid_norsp2", {28'd0, rsp_valid}, 32'd0);
        req_valid = 4'b1111;
        #1;
        check("mid_next", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        step();
        check("mid_op_rsp", {28'd0, rsp_valid}, 32'h1);
        step();

`ifdef ADDER_ARB_STATS_EN
        // Saturation: start near the top and complete two more operations
        dut.stat_ops = 16'hFFFE;
        do_op("sat1", 4'b0010, 4'b0010, 7'd8);
        check("sat1_stat", {16'd0, stat_ops}, 32'hFFFF);
        do_op("sat2", 4'b0100, 4'b0100, 7'd10);
        check("sat2_stat", {16'd0, stat_ops}, 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
